pe_out_chan: RTL and testbench

PE output channel; it is the consumer end of the FU output interface (alloc / valid / data / ready).
- Accepts slot reservations (fu_alloc) and later result writes (fu_valid, fu_out) from the PE functional unit.
- Buffers results in a small FIFO and broadcasts each head entry to up to NUM_DST configured destinations.
- An entry retires only when every enabled destination has accepted it. Drives out_ready back to the FU.

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_chan_fifo.sv | 65 ++++++
 rtl/pe_out_chan.sv | 106 ++++++++++
 tb/tb_pe_out_chan.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE output channel.
// The optional error flag in pe_out_chan is enabled with the macro PE_OUT_CHAN_ERR_EN.
package pe_pkg;

   // Default fan-out width and the largest fan-out the channel is meant for.
   localparam int PE_NUM_DST = 4;
   localparam int PE_MAX_DST = 16;

   typedef logic [PE_NUM_DST-1:0] dst_mask_t;

   // Pointer width for a FIFO of the given depth; never below one bit.
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/pe_chan_fifo.sv
// Small circular buffer for the PE output channel: storage, pointers and
// occupancy count. Callers must never write while full or read while empty.
module pe_chan_fifo
   import pe_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int DEPTH      = 2,
   localparam int PW         = ptr_w(DEPTH),
   localparam int CW         = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [CW-1:0]         occ_o,
   output logic                  empty_o,
   output logic                  full_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         occ_q, occ_d;

   // Next-state for pointers and occupancy; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en_i, rd_en_i})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control state; clear discards everything exactly like reset.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage array; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign occ_o     = occ_q;
   assign empty_o   = (occ_q == '0);
   assign full_o    = (occ_q == CW'(DEPTH));

endmodule

// File: rtl/pe_out_chan.sv
// PE output channel: consumer end of the FU alloc/valid/data/ready interface.
// The FU reserves a slot (fu_alloc while out_ready), later writes the result
// (fu_valid); each buffered entry is broadcast to every enabled destination
// and retires once all of them have taken it (valid && ready per destination).
// Optional sticky protocol-error flag: define PE_OUT_CHAN_ERR_EN.
module pe_out_chan
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int NUM_DST    = PE_NUM_DST
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  cfgd,
   input  logic [NUM_DST-1:0]    cfg_dst_mask,
   input  logic                  fu_alloc,
   input  logic                  fu_valid,
   input  logic [DATA_WIDTH-1:0] fu_out,
   output logic                  out_ready,
   output logic [NUM_DST-1:0]    dst_valid,
   output logic [DATA_WIDTH-1:0] dst_data,
   input  logic [NUM_DST-1:0]    dst_ready,
   output logic                  empty,
   output logic                  err
);

   localparam int CW = ptr_w(DEPTH) + 1;
   localparam int LW = CW + 1;

   logic [CW-1:0]      occ;
   logic               fifo_empty, fifo_full;
   logic [CW-1:0]      rsv_q, rsv_d;
   logic [NUM_DST-1:0] sent_q, sent_d;
   logic [NUM_DST-1:0] accept;
   logic [LW-1:0]      level;
   logic               alloc_ok, wr_ok, retire;

   // Slot availability depends on registered state only, never on fu_*.
   assign level     = {1'b0, occ} + {1'b0, rsv_q};
   assign out_ready = cfgd && (level < LW'(DEPTH));
   assign alloc_ok  = fu_alloc && out_ready;
   // A write is legal against an existing reservation or a same-cycle alloc.
   assign wr_ok     = cfgd && fu_valid && ((rsv_q != '0) || alloc_ok);

   assign dst_valid = {NUM_DST{cfgd && !fifo_empty}} & cfg_dst_mask & ~sent_q;
   assign accept    = dst_valid & dst_ready;
   assign retire    = cfgd && !fifo_empty && (&(sent_q | accept | ~cfg_dst_mask));
   assign empty     = fifo_empty;

   pe_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .wr_en_i   (wr_ok && !fifo_full),
      .wr_data_i (fu_out),
      .rd_en_i   (retire),
      .rd_data_o (dst_data),
      .occ_o     (occ),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   // Reservation count and head-entry delivery bits for the next cycle.
   always_comb begin
      rsv_d = rsv_q;
      if (alloc_ok && !wr_ok)      rsv_d = rsv_q + CW'(1);
      else if (wr_ok && !alloc_ok) rsv_d = rsv_q - CW'(1);
      sent_d = retire ? '0 : (sent_q | accept);
   end

   // Reservation and sent-bit registers; clear wins over any same-cycle event.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         rsv_q  <= '0;
         sent_q <= '0;
      end else begin
         rsv_q  <= rsv_d;
         sent_q <= sent_d;
      end
   end

`ifdef PE_OUT_CHAN_ERR_EN
   logic err_q;
   logic bad_evt;

   // Orphan write (no reservation) or alloc refused while configured.
   assign bad_evt = (fu_valid && (rsv_q == '0) && !alloc_ok) ||
                    (cfgd && fu_alloc && !out_ready);

   // Sticky error flag, cleared only by reset or clear.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) err_q <= 1'b0;
      else if (bad_evt)    err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pe_out_chan.sv
// Bench for pe_out_chan: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model.
module tb_pe_out_chan;

   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int ND    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          cfgd;
   logic [ND-1:0] cfg_dst_mask;
   logic          fu_alloc;
   logic          fu_valid;
   logic [DW-1:0] fu_out;
   logic          out_ready;
   logic [ND-1:0] dst_valid;
   logic [DW-1:0] dst_data;
   logic [ND-1:0] dst_ready;
   logic          empty;
   logic          err;

   int passed = 0;
   int total  = 0;

   // reference model state
   logic [DW-1:0] exp_q[$];
   int            rsv_m  = 0;
   logic [ND-1:0] sent_m = '0;
   logic          err_m  = 1'b0;

   // clock
   always #5 clk = ~clk;

   pe_out_chan #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_DST(ND)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .cfgd         (cfgd),
      .cfg_dst_mask (cfg_dst_mask),
      .fu_alloc     (fu_alloc),
      .fu_valid     (fu_valid),
      .fu_out       (fu_out),
      .out_ready    (out_ready),
      .dst_valid    (dst_valid),
      .dst_data     (dst_data),
      .dst_ready    (dst_ready),
      .empty        (empty),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   function automatic logic model_ready();
      return cfgd && ((exp_q.size() + rsv_m) < DEPTH);
   endfunction

   // compare every visible output against the model
   task automatic check_outputs();
      logic [ND-1:0] v;
      v = '0;
      for (int i = 0; i < ND; i++)
         v[i] = cfgd && (exp_q.size() > 0) && cfg_dst_mask[i] && !sent_m[i];
      chk("out_ready", DW'(out_ready), DW'(model_ready()));
      chk("empty",     DW'(empty),     DW'(exp_q.size() == 0));
      chk("dst_valid", DW'(dst_valid), DW'(v));
      chk("err",       DW'(err),       DW'(err_m));
      if (exp_q.size() > 0) chk("dst_data", dst_data, exp_q[0]);
   endtask

   // advance the model by one clock using the inputs held at the edge
   task automatic model_step();
      logic          rdy, a, w, all_done;
      logic [ND-1:0] took;
      if (!rst_n || clear) begin
         exp_q.delete();
         rsv_m  = 0;
         sent_m = '0;
         err_m  = 1'b0;
         return;
      end
      rdy = model_ready();
      a   = fu_alloc && rdy;
      w   = cfgd && fu_valid && (rsv_m > 0 || a);
`ifdef PE_OUT_CHAN_ERR_EN
      if ((fu_valid && rsv_m == 0 && !a) || (cfgd && fu_alloc && !rdy)) err_m = 1'b1;
`endif
      if (cfgd && exp_q.size() > 0) begin
         all_done = 1'b1;
         took     = '0;
         for (int i = 0; i < ND; i++) begin
            if (cfg_dst_mask[i] && !sent_m[i] && dst_ready[i]) took[i] = 1'b1;
            if (cfg_dst_mask[i] && !sent_m[i] && !dst_ready[i]) all_done = 1'b0;
         end
         if (all_done) begin
            void'(exp_q.pop_front());
            sent_m = '0;
         end else begin
            sent_m = sent_m | took;
         end
      end
      if (w) exp_q.push_back(fu_out);
      if (a && !w) rsv_m++;
      else if (w && !a) rsv_m--;
   endtask

   task automatic cycle();
      #1;
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      fu_alloc  = 1'b0;
      fu_valid  = 1'b0;
      dst_ready = '0;
      clear     = 1'b0;
   endtask

   task automatic push(input logic alloc, input logic [DW-1:0] d);
      fu_alloc = alloc;
      fu_valid = 1'b1;
      fu_out   = d;
      cycle();
      fu_alloc = 1'b0;
      fu_valid = 1'b0;
   endtask

   initial begin
      logic exp_err;
      // reset
      rst_n = 1'b0; clear = 1'b0; cfgd = 1'b0; cfg_dst_mask = '0;
      fu_alloc = 1'b0; fu_valid = 1'b0; fu_out = '0; dst_ready = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("reset_out_ready", DW'(out_ready), '0);
      chk("reset_empty",     DW'(empty),     DW'(1));

      // 1: single entry to two destinations
      cfgd = 1'b1; cfg_dst_mask = 4'b0011; idle();
      cycle();
      fu_alloc = 1'b1; cycle(); fu_alloc = 1'b0;
      cycle();
      push(1'b0, 32'hA5);
      chk("t1_dst_valid", DW'(dst_valid), DW'(4'b0011));
      chk("t1_dst_data",  dst_data, 32'hA5);
      dst_ready = 4'b0011; cycle(); dst_ready = '0;
      chk("t1_empty", DW'(empty), DW'(1));
      chk("t1_out_ready", DW'(out_ready), DW'(1));

      // 2: reservations fill the channel, third alloc refused
      fu_alloc = 1'b1; cycle(); cycle();
      chk("t2_out_ready", DW'(out_ready), '0);
      cycle(); fu_alloc = 1'b0;
`ifdef PE_OUT_CHAN_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      chk("t2_err", DW'(err), DW'(exp_err));
      push(1'b0, 32'h22);
      push(1'b0, 32'h33);
      dst_ready = 4'b0011; repeat (3) cycle(); dst_ready = '0;

      // 3: fan-out skew
      cfg_dst_mask = 4'b0111;
      push(1'b1, 32'h11);
      dst_ready = 4'b0001; cycle(); dst_ready = '0; cycle();
      chk("t3_partial", DW'(dst_valid), DW'(4'b0110));
      dst_ready = 4'b0100; cycle(); dst_ready = '0; cycle();
      chk("t3_last", DW'(dst_valid), DW'(4'b0010));
      dst_ready = 4'b0010; cycle(); dst_ready = '0;
      chk("t3_retired", DW'(empty), DW'(1));
      cycle();

      // 4: orphan write
      push(1'b0, 32'hDEAD);
      chk("t4_empty", DW'(empty), DW'(1));
      clear = 1'b1; cycle(); clear = 1'b0;

      // 5: full FIFO, write in the same cycle as head retire
      cfg_dst_mask = 4'b1111;
      push(1'b1, 32'h1);
      push(1'b1, 32'h2);
      chk("t5_full", DW'(out_ready), '0);
      dst_ready = 4'b1111; cycle();
      push(1'b1, 32'h3);
      chk("t5_head", dst_data, 32'h3);
      repeat (2) cycle();
      dst_ready = '0;

      // 6: clear mid-transfer
      cfg_dst_mask = 4'b0011;
      push(1'b1, 32'h44);
      push(1'b1, 32'h55);
      dst_ready = 4'b0001; cycle(); dst_ready = '0;
      fu_valid = 1'b1; fu_out = 32'hBAD; cycle(); fu_valid = 1'b0;
      clear = 1'b1; cycle(); clear = 1'b0;
      chk("t6_empty",     DW'(empty),     DW'(1));
      chk("t6_dst_valid", DW'(dst_valid), '0);
      chk("t6_out_ready", DW'(out_ready), DW'(1));
      chk("t6_err",       DW'(err),       '0);

      // sink mode: no destinations enabled
      cfg_dst_mask = 4'b0000;
      push(1'b1, 32'h77);
      chk("sink_visible", DW'(empty), '0);
      cycle();
      chk("sink_retired", DW'(empty), DW'(1));

      // random traffic
      for (int n = 0; n < 600; n++) begin
         rst_n    = ($urandom_range(0, 149) != 0);
         clear    = ($urandom_range(0, 59) == 0);
         cfgd     = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 24) == 0) cfg_dst_mask = ND'($urandom_range(0, 15));
         fu_alloc  = $urandom_range(0, 1);
         fu_valid  = ($urandom_range(0, 2) != 0);
         fu_out    = $urandom;
         dst_ready = ND'($urandom_range(0, 15));
         cycle();
      end
      idle();
      rst_n = 1'b1;
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
